// File: rtl/urv_mem_pkg.sv
// urv_mem_pkg
// Shared definitions for the uRV memory arbiter slice:
//   owner_e        - who owns the read return in the cycle after a grant
//   WORD_LANES     - byte lanes per RAM word
//   STARVE_W       - width of the fetch starvation counter (covers 1..15)
//   addr_in_range  - true when no byte-address bit at or above addr_w is set
package urv_mem_pkg;

  localparam int WORD_LANES = 4;
  localparam int STARVE_W   = 4;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  // Anything with a set bit in [31:addr_w] falls outside the RAM.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input int unsigned addr_w);
    logic [31:0] hi_mask;
    hi_mask = (addr_w >= 32) ? 32'h0 : ~((32'h1 << addr_w) - 32'h1);
    return (addr & hi_mask) == 32'h0;
  endfunction

endpackage

// File: rtl/urv_arb_starve_cnt.sv
// urv_arb_starve_cnt
// Saturating counter of consecutive cycles a pending fetch has been denied.
// Ports:
//   wclk   - clock
//   rst    - asynchronous active-low reset
//   inc    - fetch pending and denied this cycle
//   clr    - fetch granted or not requesting this cycle (wins over inc)
//   at_max - counter has reached MAX; fetch must win this cycle
// MAX must lie in 1..2**W-1.
module urv_arb_starve_cnt
  import urv_mem_pkg::*;
#(
  parameter int MAX = 4,
  parameter int W   = STARVE_W
) (
  input  logic wclk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/urv_mem_arbiter.sv
// urv_mem_arbiter
// Shares one single-port synchronous word RAM between the uRV fetch port and
// the data load/store port. One grant per cycle; data wins by default, but a
// fetch denied STARVE_MAX cycles in a row is forced through. Read data returns
// one cycle after the grant.
// Ports:
//   wclk, rst                  - clock, asynchronous active-low reset
//   i_req/i_addr               - fetch request (held until i_gnt)
//   i_gnt/i_rvalid/i_rdata     - fetch grant (comb) and read return
//   d_req/d_we/d_addr/d_wdata/d_be - data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata     - data grant (comb) and load return
//   d_err                      - out-of-range data access, aligned with return
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata - RAM macro port
module urv_mem_arbiter
  import urv_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  input  logic [WORD_LANES-1:0] d_be,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  d_err,
  output logic                  mem_en,
  output logic [WORD_LANES-1:0] mem_we,
  output logic [ADDR_W-3:0]     mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  logic   starve_at_max;
  logic   i_in_range;
  logic   d_in_range;
  owner_e rd_owner_q, rd_owner_d;
  logic   rd_load_q, rd_load_d;
  logic   rd_oor_q, rd_oor_d;

  assign i_in_range = addr_in_range(i_addr, ADDR_W);
  assign d_in_range = addr_in_range(d_addr, ADDR_W);

  // Grants are gated by reset so nothing reaches the RAM while rst is low.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (rst) begin
      if (i_req && (!d_req || starve_at_max)) begin
        i_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  urv_arb_starve_cnt #(
    .MAX (STARVE_MAX),
    .W   (STARVE_W)
  ) u_starve (
    .wclk   (wclk),
    .rst    (rst),
    .inc    (i_req && !i_gnt),
    .clr    (!i_req || i_gnt),
    .at_max (starve_at_max)
  );

  // Out-of-range accesses are still granted but leave the RAM disabled.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = d_addr[ADDR_W-1:2];
    mem_wdata = d_wdata;
    if (i_gnt) begin
      mem_addr = i_addr[ADDR_W-1:2];
      mem_en   = i_in_range;
    end else if (d_gnt) begin
      mem_en = d_in_range;
      if (d_in_range && d_we) begin
        mem_we = d_be;
      end
    end
  end

  always_comb begin
    rd_owner_d = OWNER_NONE;
    rd_load_d  = 1'b0;
    rd_oor_d   = 1'b0;
    if (i_gnt) begin
      rd_owner_d = OWNER_FETCH;
      rd_oor_d   = !i_in_range;
    end else if (d_gnt) begin
      rd_owner_d = OWNER_DATA;
      rd_load_d  = !d_we;
      rd_oor_d   = !d_in_range;
    end
  end

  // An async reset wipes the owner, so a return in flight is never emitted.
  always_ff @(posedge wclk or negedge rst) begin
    if (!rst) begin
      rd_owner_q <= OWNER_NONE;
      rd_load_q  <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_owner_q <= rd_owner_d;
      rd_load_q  <= rd_load_d;
      rd_oor_q   <= rd_oor_d;
    end
  end

  assign i_rvalid = (rd_owner_q == OWNER_FETCH);
  assign d_rvalid = (rd_owner_q == OWNER_DATA) && rd_load_q;
  assign d_err    = (rd_owner_q == OWNER_DATA) && rd_oor_q;
  assign i_rdata  = rd_oor_q ? 32'h0 : mem_rdata;
  assign d_rdata  = rd_oor_q ? 32'h0 : mem_rdata;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// tb_urv_mem_arbiter
// Directed and randomized checks of urv_mem_arbiter against a behavioural
// model: arbitration from an integer starvation count, a word-array copy of
// memory updated from the requests, and a one-entry expected return.
module tb_urv_mem_arbiter;

  localparam int ADDR_W     = 16;
  localparam int STARVE_MAX = 4;
  localparam int DEPTH      = 2 ** (ADDR_W - 2);
  localparam int RET_NONE   = 0;
  localparam int RET_FETCH  = 1;
  localparam int RET_LOAD   = 2;

  logic              wclk;
  logic              rst;
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_gnt;
  logic              i_rvalid;
  logic [31:0]       i_rdata;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic [31:0] model_mem [DEPTH];
  int          starve   = 0;
  int          ret_kind = RET_NONE;
  logic [31:0] ret_data = 32'h0;
  logic        ret_err  = 1'b0;
  logic        m_ei     = 1'b0;
  logic        m_ed     = 1'b0;

  // RAM macro stand-in
  logic [31:0] ram [DEPTH];

  logic i_pend_q;
  logic d_pend_q;

  urv_mem_arbiter #(
    .ADDR_W     (ADDR_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .wclk      (wclk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_gnt     (i_gnt),
    .i_rvalid  (i_rvalid),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  // Single-port synchronous RAM: byte-lane writes, registered read when no lane is written.
  always @(posedge wclk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      if (mem_we == 4'b0000) mem_rdata <= ram[mem_addr];
    end
  end

  // Requesters must hold a request until it is granted.
  always @(posedge wclk or negedge rst) begin
    if (!rst) begin
      i_pend_q <= 1'b0;
      d_pend_q <= 1'b0;
    end else begin
      assert (!(i_pend_q && !i_req)) else $error("[TB] protocol: fetch request withdrawn before grant");
      assert (!(d_pend_q && !d_req)) else $error("[TB] protocol: data request withdrawn before grant");
      i_pend_q <= i_req && !i_gnt;
      d_pend_q <= d_req && !d_gnt;
    end
  end

  function automatic logic [31:0] initWord(input int w);
    return (w == 'hFD) ? 32'h0 : (32'hA5C3_0000 | 32'(w));
  endfunction

  function automatic logic inRange(input logic [31:0] a);
    return longint'(a) < (longint'(1) << ADDR_W);
  endfunction

  function automatic logic [31:0] randAddr();
    logic [31:0] a;
    if ($urandom_range(0, 11) == 0)
      a = {16'($urandom_range(1, 65535)), 16'($urandom)};
    else
      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
    return a;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic dwe, input logic [31:0] daddr,
                               input logic [31:0] dwdata, input logic [3:0] dbe);
    i_req   = ireq;
    i_addr  = iaddr;
    d_req   = dreq;
    d_we    = dwe;
    d_addr  = daddr;
    d_wdata = dwdata;
    d_be    = dbe;
  endtask

  task automatic nextCycle();
    @(posedge wclk);
    #1;
  endtask

  task automatic modelReset();
    ret_kind = RET_NONE;
    ret_err  = 1'b0;
    starve   = 0;
  endtask

  // At the falling edge: check the return from last cycle and this cycle's
  // grant/RAM port, then advance the model as the coming rising edge will.
  task automatic runCycle();
    logic i_inr, d_inr, e_en;
    logic [3:0] e_we;
    int w;
    @(negedge wclk);
    checkOutput("i_rvalid", 32'(i_rvalid), 32'(ret_kind == RET_FETCH));
    checkOutput("d_rvalid", 32'(d_rvalid), 32'(ret_kind == RET_LOAD));
    checkOutput("d_err", 32'(d_err), 32'(ret_err));
    if (ret_kind == RET_FETCH) checkOutput("i_rdata", i_rdata, ret_data);
    if (ret_kind == RET_LOAD) checkOutput("d_rdata", d_rdata, ret_data);

    i_inr = inRange(i_addr);
    d_inr = inRange(d_addr);
    m_ei  = rst && i_req && (!d_req || starve >= STARVE_MAX);
    m_ed  = rst && d_req && !m_ei;
    e_en  = (m_ei && i_inr) || (m_ed && d_inr);
    e_we  = (m_ed && d_inr && d_we) ? d_be : 4'b0000;
    checkOutput("i_gnt", 32'(i_gnt), 32'(m_ei));
    checkOutput("d_gnt", 32'(d_gnt), 32'(m_ed));
    checkOutput("mem_en", 32'(mem_en), 32'(e_en));
    checkOutput("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) checkOutput("mem_addr", 32'(mem_addr), (m_ei ? i_addr : d_addr) >> 2);
    if (e_we != 4'b0000) checkOutput("mem_wdata", mem_wdata, d_wdata);

    ret_kind = RET_NONE;
    ret_err  = 1'b0;
    ret_data = 32'h0;
    if (!rst) begin
      starve = 0;
    end else begin
      if (m_ei) begin
        ret_kind = RET_FETCH;
        ret_data = i_inr ? model_mem[i_addr >> 2] : 32'h0;
      end else if (m_ed) begin
        ret_err = !d_inr;
        w = int'(d_addr >> 2);
        if (!d_we) begin
          ret_kind = RET_LOAD;
          ret_data = d_inr ? model_mem[w] : 32'h0;
        end else if (d_inr) begin
          for (int b = 0; b < 4; b++)
            if (d_be[b]) model_mem[w][8*b +: 8] = d_wdata[8*b +: 8];
        end
      end
      if (!i_req || m_ei) starve = 0;
      else if (starve < STARVE_MAX) starve = starve + 1;
    end
  endtask

  // Directed steps from reset through starvation and out-of-range, then random traffic.
  initial begin
    logic        r_ireq, r_dreq, r_dwe;
    logic [31:0] r_iaddr, r_daddr, r_dwdata;
    logic [3:0]  r_dbe;

    for (int w = 0; w < DEPTH; w++) begin
      ram[w]       = initWord(w);
      model_mem[w] = initWord(w);
    end
    mem_rdata = 32'h0;
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0000_0104, 1'b1, 1'b0, 32'h0000_0008, 32'h0, 4'h0);

    // Reset with both requests up: nothing granted, RAM idle
    runCycle();
    checkOutput("rst_i_gnt", 32'(i_gnt), 32'h0);
    checkOutput("rst_d_gnt", 32'(d_gnt), 32'h0);
    checkOutput("rst_mem_en", 32'(mem_en), 32'h0);
    nextCycle();
    rst = 1'b1;
    runCycle();
    checkOutput("rel_d_gnt", 32'(d_gnt), 32'h1);
    nextCycle();

    // Fetch alone
    applyStimulus(1'b1, 32'h0000_0104, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    runCycle();
    checkOutput("fetch_gnt", 32'(i_gnt), 32'h1);
    checkOutput("fetch_mem_addr", 32'(mem_addr), 32'h41);
    nextCycle();

    // Partial store, then load back
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_03F4, 32'hAABB_CCDD, 4'b0011);
    runCycle();
    checkOutput("fetch_rvalid", 32'(i_rvalid), 32'h1);
    checkOutput("fetch_rdata", i_rdata, 32'hA5C3_0041);
    checkOutput("store_mem_we", 32'(mem_we), 32'h3);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_03F4, 32'h0, 4'h0);
    runCycle();
    checkOutput("store_no_rvalid", 32'(d_rvalid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    runCycle();
    checkOutput("load_rvalid", 32'(d_rvalid), 32'h1);
    checkOutput("load_rdata", d_rdata, 32'h0000_CCDD);
    nextCycle();

    // Starvation: data always requesting, fetch forced through after STARVE_MAX denials
    for (int k = 1; k <= STARVE_MAX + 2; k++) begin
      applyStimulus(k <= STARVE_MAX + 1, 32'h0000_0020, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 4'h0);
      runCycle();
      checkOutput("starve_i_gnt", 32'(i_gnt), 32'(k == STARVE_MAX + 1));
      checkOutput("starve_d_gnt", 32'(d_gnt), 32'(k != STARVE_MAX + 1));
      nextCycle();
    end

    // Out-of-range load and store
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h1000_0000, 32'h0, 4'h0);
    runCycle();
    checkOutput("oor_d_gnt", 32'(d_gnt), 32'h1);
    checkOutput("oor_mem_en", 32'(mem_en), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h0002_0000, 32'h1234_5678, 4'hF);
    runCycle();
    checkOutput("oor_ld_rvalid", 32'(d_rvalid), 32'h1);
    checkOutput("oor_ld_rdata", d_rdata, 32'h0);
    checkOutput("oor_ld_err", 32'(d_err), 32'h1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    runCycle();
    checkOutput("oor_st_err", 32'(d_err), 32'h1);
    checkOutput("oor_st_rvalid", 32'(d_rvalid), 32'h0);
    nextCycle();

    // Reset between grant and return drops the return
    applyStimulus(1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    runCycle();
    checkOutput("midrst_gnt", 32'(i_gnt), 32'h1);
    #2;
    rst = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_i_rvalid_async", 32'(i_rvalid), 32'h0);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    runCycle();
    nextCycle();
    rst = 1'b1;
    runCycle();
    checkOutput("midrst_i_rvalid", 32'(i_rvalid), 32'h0);
    checkOutput("midrst_d_rvalid", 32'(d_rvalid), 32'h0);
    nextCycle();

    // Random traffic obeying the hold-until-grant protocol
    r_ireq = 1'b0; r_iaddr = 32'h0;
    r_dreq = 1'b0; r_dwe = 1'b0; r_daddr = 32'h0; r_dwdata = 32'h0; r_dbe = 4'h0;
    for (int c = 0; c < 600; c++) begin
      if (!r_ireq || m_ei) begin
        r_ireq  = ($urandom_range(0, 2) != 0);
        r_iaddr = randAddr();
      end
      if (!r_dreq || m_ed) begin
        r_dreq   = ($urandom_range(0, 3) != 0);
        r_dwe    = 1'($urandom_range(0, 1));
        r_daddr  = randAddr();
        r_dwdata = $urandom;
        r_dbe    = 4'($urandom_range(0, 15));
      end
      applyStimulus(r_ireq, r_iaddr, r_dreq, r_dwe, r_daddr, r_dwdata, r_dbe);
      runCycle();
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
